vec_fir_mac: RTL and testbench

VEC_FIR_MAC -- requirements
Module: vec_fir_mac

---
 rtl/vec_fir_mac_pkg.sv | 15 +
 rtl/vec_fir_mac_lane.sv | 83 ++++++++
 rtl/vec_fir_mac.sv | 139 +++++++++++++
 tb/tb_vec_fir_mac.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_fir_mac_pkg.sv
// Shared types and default configuration for the vec_fir_mac SIMD FIR MAC block.
package vec_fir_mac_pkg;

   localparam int LANES_DEF    = 8;
   localparam int ELEM_W_DEF   = 16;
   localparam int ACC_W_DEF    = 40;
   localparam int TAPS_MAX_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/vec_fir_mac_lane.sv
// One SIMD lane: signed multiply, wrapping accumulate, arithmetic shift and
// output conversion. Optional saturation is enabled with VEC_FIR_MAC_SAT_EN;
// without it the shifted value is truncated to ELEM_W bits.
module vec_fir_mac_lane
   import vec_fir_mac_pkg::*;
#(
   parameter int ELEM_W  = ELEM_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int SHIFT_W = $clog2(ACC_W_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              acc_en,
   input  logic              load,
   input  logic [SHIFT_W-1:0] shift,
   input  logic [ELEM_W-1:0] samp,
   input  logic [ELEM_W-1:0] coef,
   output logic [ELEM_W-1:0] result
);

   logic signed [2*ELEM_W-1:0] prod_s;
   logic signed [ACC_W-1:0]    prod_ext_s;
   logic signed [ACC_W-1:0]    shifted_s;
   logic signed [ACC_W-1:0]    acc_d;
   logic signed [ACC_W-1:0]    acc_q;
   logic [ELEM_W-1:0]          result_d;
   logic [ELEM_W-1:0]          result_q;

   // Reduce the shifted accumulator to an output element.
   function automatic logic [ELEM_W-1:0] output_conv(input logic signed [ACC_W-1:0] v);
      logic [ELEM_W-1:0] r;
`ifdef VEC_FIR_MAC_SAT_EN
      // Value fits when every bit above the output sign bit matches the sign.
      if (v[ACC_W-1:ELEM_W-1] == {(ACC_W-ELEM_W+1){v[ACC_W-1]}}) begin
         r = v[ELEM_W-1:0];
      end else if (v[ACC_W-1]) begin
         r = {1'b1, {(ELEM_W-1){1'b0}}};
      end else begin
         r = {1'b0, {(ELEM_W-1){1'b1}}};
      end
`else
      r = v[ELEM_W-1:0];
`endif
      return r;
   endfunction

   // Next accumulator and result: clear on new op, add product per beat, capture on last beat.
   always_comb begin
      prod_s     = $signed(samp) * $signed(coef);
      prod_ext_s = ACC_W'(prod_s);
      acc_d      = acc_q;
      result_d   = result_q;
      if (clr) begin
         acc_d    = '0;
         result_d = '0;
      end else if (acc_en) begin
         acc_d = acc_q + prod_ext_s;
      end else begin
         acc_d = acc_q;
      end
      shifted_s = acc_d >>> shift;
      if (load) begin
         result_d = output_conv(shifted_s);
      end else begin
         result_d = result_d;
      end
   end

   // Accumulator and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: rtl/vec_fir_mac.sv
// Top level of the SIMD FIR multiply-accumulate block: control FSM
// (IDLE/ACCUM/DONE) plus LANES instances of vec_fir_mac_lane.
// Build option: define VEC_FIR_MAC_SAT_EN for saturating output conversion.
module vec_fir_mac
   import vec_fir_mac_pkg::*;
#(
   parameter int LANES    = LANES_DEF,
   parameter int ELEM_W   = ELEM_W_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int TAPS_MAX = TAPS_MAX_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [$clog2(TAPS_MAX+1)-1:0] taps_num,
   input  logic [$clog2(ACC_W)-1:0]      shift,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*ELEM_W-1:0]       samp,
   input  logic [LANES*ELEM_W-1:0]       coef,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*ELEM_W-1:0]       result,
   output logic                          busy
);

   localparam int TAPS_W  = $clog2(TAPS_MAX+1);
   localparam int SHIFT_W = $clog2(ACC_W);

   state_e              state_d, state_q;
   logic [TAPS_W-1:0]   cnt_d, cnt_q;
   logic [TAPS_W-1:0]   taps_d, taps_q;
   logic [SHIFT_W-1:0]  shift_d, shift_q;
   logic                in_ready_d, in_ready_q;
   logic                out_valid_d, out_valid_q;
   logic                busy_d, busy_q;
   logic                clr_s;
   logic                acc_en_s;
   logic                load_s;
   logic                taps_ok_s;
   logic [TAPS_W-1:0]   cnt_inc_s;

   // Next-state logic and per-cycle lane controls.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      taps_d    = taps_q;
      shift_d   = shift_q;
      clr_s     = 1'b0;
      acc_en_s  = 1'b0;
      load_s    = 1'b0;
      taps_ok_s = (taps_num != '0) && (taps_num <= TAPS_W'(TAPS_MAX));
      cnt_inc_s = cnt_q + TAPS_W'(1);
      case (state_q)
         ST_IDLE: begin
            if (start && taps_ok_s) begin
               state_d = ST_ACCUM;
               clr_s   = 1'b1;
               cnt_d   = '0;
               taps_d  = taps_num;
               shift_d = shift;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               acc_en_s = 1'b1;
               cnt_d    = cnt_inc_s;
               if (cnt_inc_s == taps_q) begin
                  state_d = ST_DONE;
                  load_s  = 1'b1;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d  = (state_d == ST_ACCUM);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   // FSM state, counters, latched configuration and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         taps_q      <= '0;
         shift_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         taps_q      <= taps_d;
         shift_q     <= shift_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      vec_fir_mac_lane #(
         .ELEM_W  (ELEM_W),
         .ACC_W   (ACC_W),
         .SHIFT_W (SHIFT_W)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .clr    (clr_s),
         .acc_en (acc_en_s),
         .load   (load_s),
         .shift  (shift_q),
         .samp   (samp[l*ELEM_W +: ELEM_W]),
         .coef   (coef[l*ELEM_W +: ELEM_W]),
         .result (result[l*ELEM_W +: ELEM_W])
      );
   end

endmodule

// File: tb/tb_vec_fir_mac.sv
// Scoreboard bench for vec_fir_mac with default parameters.
module tb_vec_fir_mac;

   localparam int VW = 128;

   logic          clk;
   logic          reset;
   logic          start;
   logic [6:0]    taps_num;
   logic [5:0]    shift;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] samp;
   logic [VW-1:0] coef;
   logic          out_valid;
   logic          out_ready;
   logic [VW-1:0] result;
   logic          busy;

   int            n_checks;
   int            n_fail;
   logic [VW-1:0] exp_q[$];

   vec_fir_mac dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .taps_num  (taps_num),
      .shift     (shift),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .samp      (samp),
      .coef      (coef),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [6:0] t, input logic [5:0] sh);
      start    = 1'b1;
      taps_num = t;
      shift    = sh;
      tick();
      start    = 1'b0;
   endtask

   task automatic send_beat(input logic [VW-1:0] s, input logic [VW-1:0] c);
      samp     = s;
      coef     = c;
      in_valid = 1'b1;
      chk("in_ready_in_accum", VW'(in_ready), VW'(1'b1));
      chk("no_early_out_valid", VW'(out_valid), VW'(1'b0));
      tick();
      in_valid = 1'b0;
   endtask

   // Monitor: each completed output handshake is compared with the oldest expectation.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h expected no output", result);
         end else begin
            chk("result", result, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [VW-1:0] v_s;
      logic [VW-1:0] v_e;
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      start     = 1'b0;
      taps_num  = 7'd0;
      shift     = 6'd0;
      in_valid  = 1'b0;
      samp      = '0;
      coef      = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_busy", VW'(busy), VW'(1'b0));
      chk("rst_in_ready", VW'(in_ready), VW'(1'b0));
      chk("rst_out_valid", VW'(out_valid), VW'(1'b0));
      chk("rst_result", result, '0);
      tick();
      reset = 1'b1;
      tick();

      // Single tap: 2*3 in every lane, output one cycle after the beat.
      start_op(7'd1, 6'd0);
      chk("busy_after_start", VW'(busy), VW'(1'b1));
      exp_q.push_back({8{16'h0006}});
      send_beat({8{16'h0002}}, {8{16'h0003}});
      chk("latency_out_valid", VW'(out_valid), VW'(1'b1));
      tick();
      chk("drop_after_handshake", VW'(out_valid), VW'(1'b0));
      chk("idle_after_handshake", VW'(busy), VW'(1'b0));

      // Four taps with in_valid gaps: lane i = i * -1 * 4.
      for (int i = 0; i < 8; i++) v_s[i*16 +: 16] = 16'(i);
      exp_q.push_back({16'hFFE4, 16'hFFE8, 16'hFFEC, 16'hFFF0,
                       16'hFFF4, 16'hFFF8, 16'hFFFC, 16'h0000});
      start_op(7'd4, 6'd0);
      send_beat(v_s, {8{16'hFFFF}});
      tick(); tick();
      send_beat(v_s, {8{16'hFFFF}});
      tick();
      send_beat(v_s, {8{16'hFFFF}});
      send_beat(v_s, {8{16'hFFFF}});
      chk("gap_done_out_valid", VW'(out_valid), VW'(1'b1));
      tick();

      // Two taps of 0x7FFF squared: saturates or wraps depending on the build.
`ifdef VEC_FIR_MAC_SAT_EN
      exp_q.push_back({8{16'h7FFF}});
`else
      exp_q.push_back({8{16'h0002}});
`endif
      start_op(7'd2, 6'd0);
      send_beat({8{16'h7FFF}}, {8{16'h7FFF}});
      send_beat({8{16'h7FFF}}, {8{16'h7FFF}});
      tick();

      // Backpressure in DONE, shift by 4: lane i = (i+1)*16 >>> 4 = i+1.
      for (int i = 0; i < 8; i++) begin
         v_s[i*16 +: 16] = 16'(i + 1);
         v_e[i*16 +: 16] = 16'(i + 1);
      end
      out_ready = 1'b0;
      start_op(7'd1, 6'd4);
      send_beat(v_s, {8{16'h0010}});
      for (int k = 0; k < 5; k++) begin
         chk("stall_result", result, v_e);
         chk("stall_out_valid", VW'(out_valid), VW'(1'b1));
         chk("stall_in_ready", VW'(in_ready), VW'(1'b0));
         chk("stall_busy", VW'(busy), VW'(1'b1));
         tick();
      end
      exp_q.push_back(v_e);
      out_ready = 1'b1;
      start     = 1'b1;
      taps_num  = 7'd1;
      tick();
      start = 1'b0;
      chk("start_ignored_in_handshake", VW'(busy), VW'(1'b0));
      chk("handshake_out_valid_drop", VW'(out_valid), VW'(1'b0));
      tick();
      chk("still_idle", VW'(busy), VW'(1'b0));

      // Arithmetic shift of a negative value: -3 >>> 1 = -2.
      exp_q.push_back({8{16'hFFFE}});
      start_op(7'd1, 6'd1);
      send_beat({8{16'hFFFD}}, {8{16'h0001}});
      tick();

      // Reset in the middle of an operation, then a fresh single-tap op.
      start_op(7'd4, 6'd0);
      send_beat({8{16'h0005}}, {8{16'h0005}});
      send_beat({8{16'h0005}}, {8{16'h0005}});
      reset = 1'b0;
      #1;
      chk("midrst_busy", VW'(busy), VW'(1'b0));
      chk("midrst_in_ready", VW'(in_ready), VW'(1'b0));
      chk("midrst_out_valid", VW'(out_valid), VW'(1'b0));
      chk("midrst_result", result, '0);
      tick();
      reset = 1'b1;
      tick();
      exp_q.push_back({8{16'h0006}});
      start_op(7'd1, 6'd0);
      send_beat({8{16'h0002}}, {8{16'h0003}});
      tick();

      // Illegal tap counts and stray in_valid in IDLE are ignored.
      start_op(7'd0, 6'd0);
      chk("taps0_busy", VW'(busy), VW'(1'b0));
      chk("taps0_in_ready", VW'(in_ready), VW'(1'b0));
      start_op(7'd65, 6'd0);
      chk("taps65_busy", VW'(busy), VW'(1'b0));
      samp     = {8{16'h0009}};
      coef     = {8{16'h0009}};
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      chk("idle_inval_busy", VW'(busy), VW'(1'b0));
      chk("idle_inval_in_ready", VW'(in_ready), VW'(1'b0));
      chk("idle_inval_out_valid", VW'(out_valid), VW'(1'b0));
      exp_q.push_back({8{16'h0006}});
      start_op(7'd1, 6'd0);
      send_beat({8{16'h0002}}, {8{16'h0003}});
      tick();

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
      chk("scoreboard_drained", VW'(exp_q.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
